// File: rtl/sequencia_ctrl.sv
// Sequencer for the serial word detector: configures it, streams bytes MSB-first and reports hits.
// Optional SEQ_CTRL_RESTART_EN: multi-hit mode, the search continues after each hit.
module sequencia_ctrl #(
    parameter int unsigned MAX_BITS = 1024,
    parameter int unsigned POS_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_word,
    output logic             cfg_ready,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic             abort,
    output logic             det_rst_n,
    output logic             det_setar,
    output logic [7:0]       det_palavra,
    output logic             det_start,
    output logic             det_bit,
    input  logic             det_encontrado,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [POS_W-1:0] position,
    output logic [1:0]       status,
    output logic [POS_W-1:0] hit_count
);

    typedef enum logic [2:0] {
        StIdle, StClr, StSet, StArm, StRun, StDrain, StDone
    } state_e;

    localparam logic [1:0] StatFound    = 2'd0;
    localparam logic [1:0] StatLimit    = 2'd1;
    localparam logic [1:0] StatUnderrun = 2'd2;
    localparam logic [1:0] StatAbort    = 2'd3;

    state_e             state_q, state_d;
    logic [7:0]         word_q, word_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [POS_W-1:0]   n_q, n_d;
    logic               start_q, start_d;
    logic               found_q, found_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [1:0]         status_q, status_d;
    logic [POS_W-1:0]   hit_cnt_q, hit_cnt_d;

    logic byte_accept;
    logic last_bit;
    logic hit_seen;

    assign byte_ready  = !hold_full_q && (state_q == StArm || state_q == StRun);
    assign byte_accept = byte_valid && byte_ready;
    assign last_bit    = (n_q == POS_W'(MAX_BITS - 1));
    // The flag seen during a start cycle belongs to a bit the detector must not report.
    assign hit_seen    = det_encontrado && !start_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        n_d         = n_q;
        start_d     = start_q;
        found_d     = found_q;
        pos_d       = pos_q;
        status_d    = status_q;
        hit_cnt_d   = hit_cnt_q;

        if (byte_accept) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    word_d    = cfg_word;
                    found_d   = 1'b0;
                    pos_d     = '0;
                    hit_cnt_d = '0;
                    state_d   = StClr;
                end
            end
            StClr: state_d = StSet;
            StSet: state_d = StArm;
            StArm: begin
                if (abort) begin
                    status_d = StatAbort;
                    state_d  = StDone;
                end else if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_idx_d   = 3'd0;
                    n_d         = '0;
                    start_d     = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun: begin
                n_d     = n_q + POS_W'(1);
                start_d = 1'b0;
                if (abort) begin
                    status_d = StatAbort;
                    state_d  = StDone;
                end else if (hit_seen) begin
                    found_d   = 1'b1;
                    pos_d     = n_q - POS_W'(1);
                    hit_cnt_d = hit_cnt_q + POS_W'(1);
`ifdef SEQ_CTRL_RESTART_EN
                    if (last_bit) begin
                        status_d = StatLimit;
                        state_d  = StDrain;
                    end else begin
                        // Shifter holds: the same bit is re-driven with det_start to clear the flag.
                        start_d = 1'b1;
                    end
`else
                    status_d = StatFound;
                    state_d  = StDone;
`endif
                end else if (last_bit) begin
                    status_d = StatLimit;
                    state_d  = StDrain;
                end else if (bit_idx_q == 3'd7) begin
                    bit_idx_d = 3'd0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (byte_accept) begin
                        shift_d     = byte_data;
                        hold_full_d = 1'b0;
                    end else begin
                        status_d = StatUnderrun;
                        state_d  = StDrain;
                    end
                end else begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StDrain: begin
                if (!abort && det_encontrado) begin
                    found_d   = 1'b1;
                    pos_d     = n_q - POS_W'(1);
                    hit_cnt_d = hit_cnt_q + POS_W'(1);
`ifndef SEQ_CTRL_RESTART_EN
                    status_d  = StatFound;
`endif
                end
                if (abort) begin
                    status_d = StatAbort;
                end
                state_d = StDone;
            end
            StDone: begin
                hold_full_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            n_q         <= '0;
            start_q     <= 1'b0;
            found_q     <= 1'b0;
            pos_q       <= '0;
            status_q    <= '0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            n_q         <= n_d;
            start_q     <= start_d;
            found_q     <= found_d;
            pos_q       <= pos_d;
            status_q    <= status_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign cfg_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign det_rst_n   = (state_q != StClr);
    // Re-loading the word in DONE leaves the detector idle until the next start strobe.
    assign det_setar   = (state_q == StSet) || (state_q == StDone);
    assign det_palavra = word_q;
    assign det_start   = (state_q == StRun) && start_q;
    assign det_bit     = (state_q == StRun) && shift_q[7];
    assign done        = (state_q == StDone);
    assign found       = found_q;
    assign position    = pos_q;
    assign status      = status_q;
    assign hit_count   = hit_cnt_q;

endmodule

// File: tb/tb_sequencia_ctrl.sv
// Self-checking bench for sequencia_ctrl: detector model, bit-level reference model, random searches.
module tb_sequencia_ctrl;

    localparam int unsigned MaxB = 64;
    localparam int unsigned PosW = 10;
`ifdef SEQ_CTRL_RESTART_EN
    localparam bit Restart = 1'b1;
`else
    localparam bit Restart = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            cfg_valid;
    logic [7:0]      cfg_word;
    logic            cfg_ready;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            abort;
    logic            det_rst_n;
    logic            det_setar;
    logic [7:0]      det_palavra;
    logic            det_start;
    logic            det_bit;
    logic            det_encontrado;
    logic            busy;
    logic            done;
    logic            found;
    logic [PosW-1:0] position;
    logic [1:0]      status;
    logic [PosW-1:0] hit_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] stim [0:15];
    int         nstim;
    bit         over;
    bit         obs_found;
    int         obs_pos, obs_st, obs_cnt;

    sequencia_ctrl #(
        .MAX_BITS(MaxB),
        .POS_W   (PosW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_word      (cfg_word),
        .cfg_ready     (cfg_ready),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .abort         (abort),
        .det_rst_n     (det_rst_n),
        .det_setar     (det_setar),
        .det_palavra   (det_palavra),
        .det_start     (det_start),
        .det_bit       (det_bit),
        .det_encontrado(det_encontrado),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .position      (position),
        .status        (status),
        .hit_count     (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial detector: start shifts without comparing, setar idles it, flag is registered.
    logic [7:0] dm_sr, dm_word;
    logic       dm_act, dm_flag;
    always @(posedge clk or posedge rst) begin
        if (rst || !det_rst_n) begin
            dm_sr <= '0; dm_word <= '0; dm_act <= 1'b0; dm_flag <= 1'b0;
        end else if (det_setar) begin
            dm_word <= det_palavra; dm_act <= 1'b0; dm_flag <= 1'b0;
        end else if (det_start) begin
            dm_sr <= {dm_sr[6:0], det_bit}; dm_act <= 1'b1; dm_flag <= 1'b0;
        end else if (dm_act) begin
            dm_sr   <= {dm_sr[6:0], det_bit};
            dm_flag <= ({dm_sr[6:0], det_bit} == dm_word);
        end
    end
    assign det_encontrado = dm_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the stream rules, one driven bit per iteration.
    task automatic ref_model(input logic [7:0] w, output bit f, output int p, output int st,
                             output int cnt);
        int n, i, len;
        bit start, flag;
        logic [7:0] win;
        logic b;
        len = 8 * nstim; n = 0; i = 0; start = 1'b1; flag = 1'b0; win = '0;
        f = 1'b0; p = 0; st = 0; cnt = 0;
        while (1) begin
            b = stim[i / 8][7 - (i % 8)];
            if (!start && flag) begin
                cnt++; f = 1'b1; p = n - 1;
                if (!Restart) begin
                    st = 0;
                    return;
                end
                win  = {win[6:0], b};
                flag = (win == w);
                if (n == MaxB - 1) begin st = 1; break; end
                n++;
                start = 1'b1;
                continue;
            end
            win   = {win[6:0], b};
            flag  = !start && (win == w);
            start = 1'b0;
            if (n == MaxB - 1) begin st = 1; break; end
            if (i == len - 1) begin st = 2; break; end
            i++; n++;
        end
        n++;
        if (flag) begin
            cnt++; f = 1'b1; p = n - 1;
            if (!Restart) st = 0;
        end
    endtask

    task automatic run_search(input logic [7:0] w, input int gapmax);
        bit ef;
        int ep, est, ecnt;
        ref_model(w, ef, ep, est, ecnt);
        cfg_word = w; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("clr_det_rst_n", det_rst_n, 0);
        @(negedge clk);
        chk("set_strobe", {det_setar, det_palavra}, {1'b1, w});
        over = 1'b0;
        fork
            begin
                for (int k = 0; k < nstim && !over; k++) begin
                    repeat ($urandom_range(gapmax, 0)) @(negedge clk);
                    byte_data = stim[k]; byte_valid = 1'b1;
                    while (!over) begin
                        if (byte_ready) begin
                            @(negedge clk);
                            break;
                        end
                        @(negedge clk);
                    end
                    byte_valid = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (!done && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                end
                chk("done_seen", done, 1);
                obs_found = found; obs_pos = position; obs_st = status; obs_cnt = hit_count;
                chk("done_setar", {det_setar, det_palavra}, {1'b1, w});
                chk("found", found, ef);
                chk("status", status, est);
                chk("hit_count", hit_count, ecnt);
                if (ef) chk("position", position, ep[PosW-1:0]);
                over = 1'b1;
            end
        join
        @(negedge clk);
        chk("idle_after", {busy, cfg_ready, done}, 3'b010);
    endtask

    task automatic wait_start();
        int cyc;
        cyc = 0;
        while (!det_start && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("start_seen", det_start, 1);
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; cfg_valid = 1'b0; cfg_word = '0; byte_valid = 1'b0; byte_data = '0;
        abort = 1'b0; over = 1'b0; nstim = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {cfg_ready, det_rst_n, busy, byte_ready, done}, 5'b11000);
        chk("rst_det", {det_setar, det_start, det_bit, det_palavra}, 11'd0);
        chk("rst_res", {found, status, position, hit_count}, 23'd0);
        rst = 1'b0;
        @(negedge clk);

        // abort is ignored in IDLE
        abort = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle", {busy, done, cfg_ready}, 3'b001);
        abort = 1'b0;

        stim[0] = 8'h12; stim[1] = 8'hA5; nstim = 2;
        run_search(8'hA5, 0);
        chk("tp1_found", obs_found, 1);
        chk("tp1_pos", obs_pos, 15);
        chk("tp1_status", obs_st, Restart ? 2 : 0);

        stim[0] = 8'hC0; nstim = 1;
        run_search(8'h03, 0);
        chk("tp2_pos", {obs_found, obs_pos[PosW-1:0]}, {1'b1, 10'd1});

        for (int k = 0; k < 10; k++) stim[k] = 8'h00;
        nstim = 10;
        run_search(8'hFF, 0);
        chk("tp3_limit", {obs_found, obs_st[1:0]}, 3'b001);

        stim[0] = 8'h00; nstim = 1;
        run_search(8'h5A, 2);
        chk("tp4_underrun", {obs_found, obs_st[1:0]}, 3'b010);

`ifdef SEQ_CTRL_RESTART_EN
        stim[0] = 8'hAA; stim[1] = 8'h00; stim[2] = 8'hAA; nstim = 3;
        run_search(8'hAA, 0);
        chk("rs_cnt", obs_cnt, 2);
        chk("rs_pos", obs_pos, 24);
        chk("rs_status", {obs_found, obs_st[1:0]}, 3'b110);
`endif

        for (int t = 0; t < 12; t++) begin
            nstim = $urandom_range(10, 1);
            for (int k = 0; k < nstim; k++) stim[k] = 8'($urandom);
            case ($urandom_range(2, 0))
                0: w = 8'($urandom);
                1: w = stim[$urandom_range(nstim - 1, 0)];
                default: begin
                    if (nstim > 1) w = {stim[0][3:0], stim[1][7:4]};
                    else w = {4'h0, stim[0][7:4]};
                end
            endcase
            run_search(w, 3);
        end

        // abort while driving bit 3; cfg_valid while busy must not change the word
        byte_data = 8'h00; byte_valid = 1'b1;
        cfg_word = 8'hFF; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_start();
        @(negedge clk);
        cfg_word = 8'h11; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; byte_valid = 1'b0;
        chk("abort_done", {done, status}, 3'b111);
        chk("abort_word", det_palavra, 8'hFF);
        @(negedge clk);
        chk("abort_idle_after", {busy, cfg_ready}, 2'b01);

        // reset in the middle of RUN
        byte_data = 8'h00; byte_valid = 1'b1;
        cfg_word = 8'hFF; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", {cfg_ready, det_rst_n, busy, byte_ready, done}, 5'b11000);
        chk("midrst_det", {det_setar, det_start, det_bit, det_palavra}, 11'd0);
        chk("midrst_res", {found, status, position, hit_count}, 23'd0);
        @(negedge clk);
        byte_valid = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {busy, done, cfg_ready}, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
